// File: rtl/elixirchip_es1_spu_ctl_pkg.sv
// Shared types for the ES1 SPU control stages: FSM state encoding and the default count type.
package elixirchip_es1_spu_ctl_pkg;

    localparam int COUNT_WIDTH_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic [COUNT_WIDTH_DEF-1:0] count_t;

endpackage

// File: rtl/elixirchip_es1_spu_ctl_loop_interval.sv
// Inter-beat gap down-counter, used only when ELIXIRCHIP_ES1_SPU_CTL_LOOP_INTERVAL_EN is defined.
module elixirchip_es1_spu_ctl_loop_interval (
    input  logic       reset,
    input  logic       clk,
    input  logic       cke,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic       zero
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (cke) begin
            if (load)
                r_cnt <= load_val;
            else if (tick && (r_cnt != 8'd0))
                r_cnt <= r_cnt - 8'd1;
        end
    end

    assign zero = (r_cnt == 8'd0);

endmodule

// File: rtl/elixirchip_es1_spu_ctl_loop.sv
// Loop sequencer: one command of N iterations becomes N indexed beats with first/last/done.
// Optional inter-beat gap under ELIXIRCHIP_ES1_SPU_CTL_LOOP_INTERVAL_EN.
module elixirchip_es1_spu_ctl_loop
    import elixirchip_es1_spu_ctl_pkg::*;
#(
    parameter int    COUNT_WIDTH = COUNT_WIDTH_DEF,
    parameter string DEVICE      = "RTL",
    parameter string SIMULATION  = "false",
    parameter string DEBUG       = "false"
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   cke,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [COUNT_WIDTH-1:0] s_count,
`ifdef ELIXIRCHIP_ES1_SPU_CTL_LOOP_INTERVAL_EN
    input  logic [7:0]             s_interval,
`endif
    output logic                   m_valid,
    output logic                   m_first,
    output logic                   m_last,
    output logic [COUNT_WIDTH-1:0] m_index,
    output logic                   m_done,
    output logic                   busy
);

    if ((SIMULATION == "true") && (DEBUG == "true") && (DEVICE != "")) begin : g_sim_debug
    end

    state_t                 r_state;
    state_t                 w_next_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_index;
    logic                   r_valid;
    logic                   r_first;
    logic                   r_last;
    logic                   r_done;

    logic                   w_gap_zero;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_advance;
    logic [COUNT_WIDTH-1:0] w_index_nxt;
    logic                   w_last_nxt;

    assign w_accept    = cke && s_valid && s_ready;
    assign w_start     = w_accept && (s_count != '0);
    assign w_advance   = cke && (r_state == ST_RUN) && w_gap_zero && !r_last;
    assign w_index_nxt = r_index + COUNT_WIDTH'(1);
    // Compare against the latched N rather than wrapping the index.
    assign w_last_nxt  = (w_index_nxt == (r_count - COUNT_WIDTH'(1)));

`ifdef ELIXIRCHIP_ES1_SPU_CTL_LOOP_INTERVAL_EN
    logic [7:0] r_interval;
    logic       w_gap_load;

    // Gap is armed only after a non-last beat, so the last beat never blocks s_ready.
    assign w_gap_load = (w_start && (s_count != COUNT_WIDTH'(1))) || (w_advance && !w_last_nxt);

    always_ff @(posedge clk) begin
        if (reset)
            r_interval <= 8'd0;
        else if (w_accept)
            r_interval <= s_interval;
    end

    elixirchip_es1_spu_ctl_loop_interval u_interval (
        .reset    (reset),
        .clk      (clk),
        .cke      (cke),
        .load     (w_gap_load),
        .load_val (w_start ? s_interval : r_interval),
        .tick     (r_state == ST_RUN),
        .zero     (w_gap_zero)
    );
`else
    assign w_gap_zero = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else if (cke)
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_RUN;
            ST_RUN:  if (w_gap_zero && r_last && !w_start) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = (r_state == ST_IDLE) || ((r_state == ST_RUN) && r_last && w_gap_zero);
        busy    = (r_state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else if (cke) begin
            if (w_accept)
                r_count <= s_count;
            if (w_start) begin
                r_valid <= 1'b1;
                r_index <= '0;
                r_first <= 1'b1;
                r_last  <= (s_count == COUNT_WIDTH'(1));
                r_done  <= (s_count == COUNT_WIDTH'(1));
            end else if (w_accept) begin
                // N=0: bare done pulse, no beat.
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
                r_done  <= 1'b1;
            end else if (w_advance) begin
                r_valid <= 1'b1;
                r_index <= w_index_nxt;
                r_first <= 1'b0;
                r_last  <= w_last_nxt;
                r_done  <= w_last_nxt;
            end else begin
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
                r_done  <= 1'b0;
            end
        end
    end

    assign m_valid = r_valid;
    assign m_first = r_first;
    assign m_last  = r_last;
    assign m_index = r_index;
    assign m_done  = r_done;

endmodule
